// File: rtl/rem_mod_n.sv
// rem_mod_n: streaming remainder of a serially received number modulo N.
// Chunks of W bits arrive MSB-first (Horner form) or LSB-first (weighted
// accumulation). Every reduction is a shift followed by one conditional
// subtract, so the datapath never needs a divider or anything wider than RW+1.
module rem_mod_n #(
    parameter  int N         = 5,
    parameter  int W         = 1,
    parameter  int MSB_FIRST = 1,
    localparam int RW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic [RW-1:0] rem,
    output logic          div,
    output logic          out_valid,
    output logic [15:0]   bit_count
);

    if (N < 2 || N > 255) begin : g_bad_n
        $error("rem_mod_n: N must be in 2..255");
    end
    if (W < 1 || W > 8) begin : g_bad_w
        $error("rem_mod_n: W must be in 1..8");
    end
    if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_m
        $error("rem_mod_n: MSB_FIRST must be 0 or 1");
    end

    localparam logic [RW:0] NV = (RW+1)'(N);

    // Weight of the next LSB-first chunk, 2^(bits so far) mod N.
    logic [RW-1:0] wt;

    logic [RW:0]   acc;
    logic [RW:0]   tw;
    logic [16:0]   cnt_sum;
    logic [RW-1:0] rem_nxt;
    logic [RW-1:0] wt_nxt;
    logic [15:0]   cnt_nxt;

    // Next-state datapath: clear restarts from zero, then the chunk (if any)
    // is folded in one bit at a time with a single conditional subtract.
    always_comb begin
        acc     = clear ? '0 : {1'b0, rem};
        tw      = clear ? (RW+1)'(1) : {1'b0, wt};
        cnt_sum = (clear ? 17'd0 : {1'b0, bit_count}) + 17'(W);
        cnt_nxt = clear ? '0 : bit_count;
        if (in_valid) begin
            if (MSB_FIRST != 0) begin
                // acc < N <= 2^RW, so acc[RW] is 0 and the shift is exact 2*acc+bit
                for (int i = W-1; i >= 0; i--) begin
                    acc = {acc[RW-1:0], in_data[i]};
                    if (acc >= NV) acc = acc - NV;
                end
            end
            // LSB-first: add the current weight for each set bit, then double it
            for (int i = 0; i < W; i++) begin
                if (MSB_FIRST == 0 && in_data[i]) begin
                    acc = acc + tw;
                    if (acc >= NV) acc = acc - NV;
                end
                tw = {tw[RW-1:0], 1'b0};
                if (tw >= NV) tw = tw - NV;
            end
            cnt_nxt = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
        rem_nxt = acc[RW-1:0];
        wt_nxt  = tw[RW-1:0];
    end

    // State and output registers; reset beats clear beats accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            wt        <= RW'(1);
            bit_count <= '0;
            div       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            rem       <= rem_nxt;
            wt        <= wt_nxt;
            bit_count <= cnt_nxt;
            div       <= (rem_nxt == '0) && (cnt_nxt != '0);
            out_valid <= in_valid;
        end
    end

endmodule
